plot_arbiter: RTL and testbench

- Shares the single vga_adapter pixel-write port between two tron datapaths (player A, player B) and a built-in screen-clear sequencer.
- Replaces the free-running alternate-every-cycle mux with a request/acknowledge round-robin arbiter, so no pixel is lost or duplicated.
- Sits between the two tron datapath/control pairs and the VGA adapter, all in the CLOCK_50 domain.

---
 rtl/plot_arbiter_pkg.sv | 26 ++
 rtl/plot_arbiter_screen_sweep_counter.sv | 55 +++++
 rtl/plot_arbiter.sv | 147 ++++++++++++++
 tb/tb_plot_arbiter.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/plot_arbiter_pkg.sv
// Shared constants and encodings for the pixel-write arbiter.
// Screen geometry, colour width and the state / requester encodings used
// by plot_arbiter and screen_sweep_counter.
package plot_pkg;

  localparam int X_W = 8;
  localparam int Y_W = 7;
  localparam int C_W = 3;

  localparam logic [X_W-1:0] X_MAX        = 8'd159;
  localparam logic [Y_W-1:0] Y_MAX        = 7'd119;
  localparam logic [C_W-1:0] CLEAR_COLOUR = 3'b000;

  // Arbiter top-level state: servicing players, or sweeping the screen.
  typedef enum logic {
    ARB   = 1'b0,
    CLEAR = 1'b1
  } arb_state_t;

  // Identity of a requester, used to remember who was granted last.
  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_t;

endpackage

// File: rtl/plot_arbiter_screen_sweep_counter.sv
// Raster counter for the full-screen clear.
// x/y always hold the next pixel to emit. A start pulse (while idle) emits
// (0,0) on the same edge the sweep becomes busy; each following busy cycle
// emits one more pixel. last goes high once (X_MAX,Y_MAX) has been emitted,
// and the sweep goes idle on the edge after that, with x/y back at (0,0).
module screen_sweep_counter
  import plot_pkg::*;
(
  input  logic           CLOCK_50,
  input  logic           resetn,
  input  logic           start,
  output logic           busy,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           last
);

  logic advance;
  logic at_end;

  assign advance = (start && !busy) || (busy && !last);
  assign at_end  = (x == X_MAX) && (y == Y_MAX);

  // Raster position, busy window and end-of-frame flag.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      busy <= 1'b0;
      last <= 1'b0;
      x    <= '0;
      y    <= '0;
    end else begin
      if (start && !busy) begin
        busy <= 1'b1;
      end else if (busy && last) begin
        busy <= 1'b0;
      end

      if (busy && last) begin
        last <= 1'b0;
      end else if (advance && at_end) begin
        last <= 1'b1;
      end

      if (advance) begin
        if (x == X_MAX) begin
          x <= '0;
          y <= (y == Y_MAX) ? '0 : y + 1'b1;
        end else begin
          x <= x + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/plot_arbiter.sv
// Round-robin request/acknowledge arbiter for the single VGA pixel-write
// port, shared by two players and a built-in screen-clear sweep.
// Optional build macro PLOT_ARB_BOUNDS_EN: off-screen player pixels are
// acknowledged but not plotted, and raise a sticky oob_err flag.
module plot_arbiter
  import plot_pkg::*;
(
  input  logic           CLOCK_50,
  input  logic           resetn,
  input  logic           req_a,
  input  logic [X_W-1:0] x_a,
  input  logic [Y_W-1:0] y_a,
  input  logic [C_W-1:0] c_a,
  output logic           ack_a,
  input  logic           req_b,
  input  logic [X_W-1:0] x_b,
  input  logic [Y_W-1:0] y_b,
  input  logic [C_W-1:0] c_b,
  output logic           ack_b,
  input  logic           clear_req,
  output logic           clear_busy,
  output logic [X_W-1:0] vga_x,
  output logic [Y_W-1:0] vga_y,
  output logic [C_W-1:0] vga_colour,
  output logic           vga_plot,
  output logic           oob_err
);

  arb_state_t     state;
  req_id_t        last_grant;
  logic           clear_pend;
  logic           grant_en;
  logic           grant_a;
  logic           grant_b;
  logic           sweep_start;
  logic           sweep_busy;
  logic           sweep_last;
  logic [X_W-1:0] sweep_x;
  logic [Y_W-1:0] sweep_y;
  logic           a_ok;
  logic           b_ok;

  // A clear request that collided with a player grant is held in
  // clear_pend; while it is pending no further grants are given so the
  // sweep starts on the very next edge.
  assign grant_en = (state == ARB) && !clear_pend;
  assign grant_a  = grant_en && req_a && (!req_b || (last_grant == REQ_B));
  assign grant_b  = grant_en && req_b && (!req_a || (last_grant == REQ_A));
  assign ack_a    = grant_a;
  assign ack_b    = grant_b;

  assign sweep_start = (state == ARB) &&
                       (clear_pend || (clear_req && !grant_a && !grant_b));
  assign clear_busy  = sweep_busy;

`ifdef PLOT_ARB_BOUNDS_EN
  logic oob_err_reg;

  assign a_ok    = (x_a <= X_MAX) && (y_a <= Y_MAX);
  assign b_ok    = (x_b <= X_MAX) && (y_b <= Y_MAX);
  assign oob_err = oob_err_reg;

  // Sticky flag: any granted off-screen pixel latches it until reset.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      oob_err_reg <= 1'b0;
    end else if ((grant_a && !a_ok) || (grant_b && !b_ok)) begin
      oob_err_reg <= 1'b1;
    end
  end
`else
  assign a_ok    = 1'b1;
  assign b_ok    = 1'b1;
  assign oob_err = 1'b0;
`endif

  screen_sweep_counter u_sweep (
    .CLOCK_50 (CLOCK_50),
    .resetn   (resetn),
    .start    (sweep_start),
    .busy     (sweep_busy),
    .x        (sweep_x),
    .y        (sweep_y),
    .last     (sweep_last)
  );

  // Arbiter FSM with registered pixel outputs to the VGA adapter.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state      <= ARB;
      last_grant <= REQ_B;
      clear_pend <= 1'b0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_plot   <= 1'b0;
    end else begin
      vga_plot <= 1'b0;
      case (state)
        ARB: begin
          if (grant_a) begin
            last_grant <= REQ_A;
            if (a_ok) begin
              vga_x      <= x_a;
              vga_y      <= y_a;
              vga_colour <= c_a;
              vga_plot   <= 1'b1;
            end
          end else if (grant_b) begin
            last_grant <= REQ_B;
            if (b_ok) begin
              vga_x      <= x_b;
              vga_y      <= y_b;
              vga_colour <= c_b;
              vga_plot   <= 1'b1;
            end
          end

          if (sweep_start) begin
            state      <= CLEAR;
            clear_pend <= 1'b0;
            vga_x      <= sweep_x;
            vga_y      <= sweep_y;
            vga_colour <= CLEAR_COLOUR;
            vga_plot   <= 1'b1;
          end else if (clear_req && (grant_a || grant_b)) begin
            clear_pend <= 1'b1;
          end
        end

        CLEAR: begin
          if (sweep_last) begin
            state <= ARB;
          end else begin
            vga_x      <= sweep_x;
            vga_y      <= sweep_y;
            vga_colour <= CLEAR_COLOUR;
            vga_plot   <= 1'b1;
          end
        end

        default: state <= ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_plot_arbiter.sv
// Directed self-checking bench for plot_arbiter.
module tb_plot_arbiter;

  logic       CLOCK_50 = 1'b0;
  logic       resetn;
  logic       req_a;
  logic [7:0] x_a;
  logic [6:0] y_a;
  logic [2:0] c_a;
  logic       ack_a;
  logic       req_b;
  logic [7:0] x_b;
  logic [6:0] y_b;
  logic [2:0] c_b;
  logic       ack_b;
  logic       clear_req;
  logic       clear_busy;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  logic       oob_err;

  int checks   = 0;
  int failures = 0;

  plot_arbiter dut (
    .CLOCK_50   (CLOCK_50),
    .resetn     (resetn),
    .req_a      (req_a),
    .x_a        (x_a),
    .y_a        (y_a),
    .c_a        (c_a),
    .ack_a      (ack_a),
    .req_b      (req_b),
    .x_b        (x_b),
    .y_b        (y_b),
    .c_b        (c_b),
    .ack_b      (ack_b),
    .clear_req  (clear_req),
    .clear_busy (clear_busy),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot),
    .oob_err    (oob_err)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  initial begin
    int busy_cnt;
    int plot_cnt;
    int bad_colour;
    int ack_seen;
    int guard;
    int last_x;
    int last_y;

    resetn    = 1'b0;
    req_a     = 1'b0;
    x_a       = '0;
    y_a       = '0;
    c_a       = '0;
    req_b     = 1'b0;
    x_b       = '0;
    y_b       = '0;
    c_b       = '0;
    clear_req = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_plot",   32'(vga_plot),   32'd0);
    check("rst_x",      32'(vga_x),      32'd0);
    check("rst_y",      32'(vga_y),      32'd0);
    check("rst_colour", 32'(vga_colour), 32'd0);
    check("rst_busy",   32'(clear_busy), 32'd0);
    check("rst_oob",    32'(oob_err),    32'd0);
    resetn = 1'b1;

    // Single request from A
    req_a = 1'b1; x_a = 8'd25; y_a = 7'd25; c_a = 3'b001;
    #1;
    check("single_ack_a", 32'(ack_a), 32'd1);
    check("single_ack_b", 32'(ack_b), 32'd0);
    tick();
    req_a = 1'b0;
    check("single_plot",   32'(vga_plot),   32'd1);
    check("single_x",      32'(vga_x),      32'd25);
    check("single_y",      32'(vga_y),      32'd25);
    check("single_colour", 32'(vga_colour), 32'd1);
    tick();
    check("single_plot_drop", 32'(vga_plot), 32'd0);
    $display("txn single_a: x=%0d y=%0d c=%0d", vga_x, vga_y, vga_colour);

    // Fresh reset, then idle for 10 cycles
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_plot", 32'(vga_plot), 32'd0);
    end

    // Continuous contention: A first, then strict alternation
    req_a = 1'b1; x_a = 8'd25;  y_a = 7'd25;  c_a = 3'b001;
    req_b = 1'b1; x_b = 8'd100; y_b = 7'd100; c_b = 3'b010;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("cont_ack_a", 32'(ack_a), (i % 2 == 0) ? 32'd1 : 32'd0);
      check("cont_ack_b", 32'(ack_b), (i % 2 == 0) ? 32'd0 : 32'd1);
      tick();
      check("cont_plot",   32'(vga_plot),   32'd1);
      check("cont_x",      32'(vga_x),      (i % 2 == 0) ? 32'd25 : 32'd100);
      check("cont_colour", 32'(vga_colour), (i % 2 == 0) ? 32'd1 : 32'd2);
      $display("txn contention %0d: x=%0d y=%0d c=%0d", i, vga_x, vga_y, vga_colour);
    end
    req_a = 1'b0;
    req_b = 1'b0;
    tick();
    check("cont_plot_drop", 32'(vga_plot), 32'd0);

    // Full clear sweep, with A requesting throughout
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    req_a = 1'b1; x_a = 8'd7; y_a = 7'd8; c_a = 3'b010;
    check("clr_start_busy",   32'(clear_busy), 32'd1);
    check("clr_start_plot",   32'(vga_plot),   32'd1);
    check("clr_start_x",      32'(vga_x),      32'd0);
    check("clr_start_y",      32'(vga_y),      32'd0);
    check("clr_start_colour", 32'(vga_colour), 32'd0);
    busy_cnt = 0; plot_cnt = 0; bad_colour = 0; ack_seen = 0; guard = 0;
    last_x = -1; last_y = -1;
    while (clear_busy === 1'b1 && guard < 20000) begin
      #1;
      busy_cnt++;
      if (vga_plot === 1'b1) begin
        plot_cnt++;
        last_x = int'(vga_x);
        last_y = int'(vga_y);
        if (vga_colour !== 3'b000) bad_colour++;
      end
      if (ack_a === 1'b1) ack_seen++;
      tick();
      guard++;
    end
    check("clr_timeout",    32'(guard < 20000), 32'd1);
    check("clr_busy_cnt",   32'(busy_cnt),   32'd19200);
    check("clr_plot_cnt",   32'(plot_cnt),   32'd19200);
    check("clr_last_x",     32'(last_x),     32'd159);
    check("clr_last_y",     32'(last_y),     32'd119);
    check("clr_bad_colour", 32'(bad_colour), 32'd0);
    check("clr_ack_during", 32'(ack_seen),   32'd0);
    $display("txn clear: busy=%0d plots=%0d last=(%0d,%0d)", busy_cnt, plot_cnt, last_x, last_y);
    check("clr_end_plot", 32'(vga_plot), 32'd0);
    #1;
    check("clr_end_ack_a", 32'(ack_a), 32'd1);
    tick();
    req_a = 1'b0;
    check("post_clr_plot", 32'(vga_plot), 32'd1);
    check("post_clr_x",    32'(vga_x),    32'd7);
    check("post_clr_y",    32'(vga_y),    32'd8);

    // Reset in the middle of a sweep at pixel (40,10)
    tick();
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    guard = 0;
    while (!(vga_x == 8'd40 && vga_y == 7'd10) && guard < 3000) begin
      tick();
      guard++;
    end
    check("mid_reach", 32'(guard < 3000), 32'd1);
    check("mid_busy",  32'(clear_busy),   32'd1);
    resetn = 1'b0;
    tick();
    check("mid_rst_plot", 32'(vga_plot),   32'd0);
    check("mid_rst_busy", 32'(clear_busy), 32'd0);
    resetn = 1'b1;
    req_a = 1'b1; x_a = 8'd3; y_a = 7'd4; c_a = 3'b101;
    #1;
    check("mid_rst_arb_ack", 32'(ack_a), 32'd1);
    tick();
    req_a = 1'b0;
    check("mid_rst_pix_x", 32'(vga_x), 32'd3);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    check("restart_busy", 32'(clear_busy), 32'd1);
    check("restart_plot", 32'(vga_plot),   32'd1);
    check("restart_x",    32'(vga_x),      32'd0);
    check("restart_y",    32'(vga_y),      32'd0);
    tick();
    check("restart_x1",   32'(vga_x),      32'd1);
    $display("txn mid_reset: restart at (0,0) then x=%0d", vga_x);

    // Off-screen request from B
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    req_b = 1'b1; x_b = 8'd170; y_b = 7'd50; c_b = 3'b101;
    #1;
    check("oob_ack_b", 32'(ack_b), 32'd1);
    tick();
    req_b = 1'b0;
`ifdef PLOT_ARB_BOUNDS_EN
    check("oob_plot", 32'(vga_plot), 32'd0);
    check("oob_err",  32'(oob_err),  32'd1);
    tick();
    tick();
    check("oob_err_sticky", 32'(oob_err), 32'd1);
`else
    check("oob_plot", 32'(vga_plot), 32'd1);
    check("oob_x",    32'(vga_x),    32'd170);
    check("oob_err",  32'(oob_err),  32'd0);
`endif
    $display("txn oob: plot=%0d x=%0d oob_err=%0d", vga_plot, vga_x, oob_err);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
